// File: rtl/calculadora.sv
// 8-digit decimal calculator controller: byte command bus in, digit-serial display writes out.
// Ports: clk, rst (async low), CMD[7:0]; busy, error, display_val[3:0], display_idx[2:0], display_wr.
module calculadora #(
  parameter int NDIG = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] CMD,
  output logic       busy,
  output logic       error,
  output logic [3:0] display_val,
  output logic [2:0] display_idx,
  output logic       display_wr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WRITE
  } state_t;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_ADD,
    OP_SUB,
    OP_MUL
  } op_t;

  localparam logic [26:0] MAXV = 27'd99_999_999;
  localparam logic [26:0] LIM8 = 27'd10_000_000;
  localparam logic [2:0]  LAST = 3'(NDIG - 1);

  // Binary to 8 display digits, leading zeros above idx0 blanked.
  function automatic logic [31:0] to_disp(input logic [26:0] b);
    logic [31:0] r;
    logic        lead;
    r = '0;
    for (int i = 26; i >= 0; i--) begin
      for (int j = 0; j < 8; j++) begin
        if (r[j*4 +: 4] >= 4'd5)
          r[j*4 +: 4] = r[j*4 +: 4] + 4'd3;
      end
      r = {r[30:0], b[i]};
    end
    lead = 1'b1;
    for (int j = 7; j >= 1; j--) begin
      if (lead && r[j*4 +: 4] == 4'd0)
        r[j*4 +: 4] = 4'hF;
      else
        lead = 1'b0;
    end
    return r;
  endfunction

  state_t            state_q, state_d;
  op_t               op_q, op_d;
  logic [7:0]        prev_q, prev_d;
  logic [26:0]       a_q, a_d;
  logic [26:0]       b_q, b_d;
  logic              ent_q, ent_d;
  logic              res_q, res_d;
  logic              err_q, err_d;
  logic              echo_q, echo_d;
  logic [2:0]        idx_q, idx_d;
  logic [4*NDIG-1:0] buf_q, buf_d;

  logic [53:0] wide;
  logic        ovf;
  logic        cmd_ok;
  logic        do_echo;
  logic [3:0]  code;
  logic [26:0] cur;

  assign busy        = (state_q != S_IDLE) && !echo_q;
  assign error       = err_q;
  assign display_wr  = (state_q == S_WRITE);
  assign display_idx = idx_q;
  assign display_val = display_wr ? buf_q[{idx_q, 2'b00} +: 4] : 4'h0;

  assign code   = CMD[3:0];
  assign cur    = ent_q ? b_q : a_q;
  assign cmd_ok = (CMD != prev_q) && (CMD[7:4] == 4'h0) && !busy &&
                  (!err_q || code == 4'hF);

  // Full-width arithmetic so a product can never wrap past the limit.
  always_comb begin
    wide = {27'd0, a_q};
    case (op_q)
      OP_ADD:  wide = {27'd0, a_q} + {27'd0, b_q};
      OP_SUB:  wide = {27'd0, a_q} - {27'd0, b_q};
      OP_MUL:  wide = {27'd0, a_q} * {27'd0, b_q};
      default: wide = {27'd0, a_q};
    endcase
  end

  assign ovf = ((op_q == OP_SUB) && (b_q > a_q)) ||
               (wide > {27'd0, MAXV});

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    prev_d  = CMD;
    a_d     = a_q;
    b_d     = b_q;
    ent_d   = ent_q;
    res_d   = res_q;
    err_d   = err_q;
    echo_d  = echo_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    do_echo = 1'b0;

    case (state_q)
      S_EXEC: begin
        state_d = S_WRITE;
        idx_d   = '0;
        if (ovf) begin
          err_d = 1'b1;
          buf_d = {NDIG{4'hE}};
        end else begin
          a_d   = wide[26:0];
          b_d   = '0;
          op_d  = OP_NONE;
          ent_d = 1'b0;
          res_d = 1'b1;
          buf_d = to_disp(wide[26:0]);
        end
      end
      S_WRITE: begin
        idx_d = idx_q + 3'd1;
        if (idx_q == LAST) begin
          state_d = S_IDLE;
          echo_d  = 1'b0;
          idx_d   = '0;
        end
      end
      default: ;
    endcase

    if (cmd_ok) begin
      unique case (1'b1)
        (code <= 4'd9): begin
          do_echo = 1'b1;
          if (res_q) begin
            // Fresh number after a result replaces it.
            a_d   = {23'd0, code};
            b_d   = '0;
            op_d  = OP_NONE;
            ent_d = 1'b0;
            res_d = 1'b0;
          end else if (cur < LIM8) begin
            if (ent_q) b_d = cur * 27'd10 + {23'd0, code};
            else       a_d = cur * 27'd10 + {23'd0, code};
          end
        end
        (code == 4'hA), (code == 4'hB), (code == 4'hC): begin
          op_d  = (code == 4'hA) ? OP_ADD :
                  (code == 4'hB) ? OP_SUB : OP_MUL;
          res_d = 1'b0;
          if (!ent_q) begin
            ent_d = 1'b1;
            b_d   = '0;
          end
        end
        (code == 4'hD): begin
          state_d = S_EXEC;
          echo_d  = 1'b0;
          idx_d   = '0;
        end
        (code == 4'hE): begin
          do_echo = 1'b1;
          if (ent_q) b_d = cur / 27'd10;
          else       a_d = cur / 27'd10;
        end
        (code == 4'hF): begin
          do_echo = 1'b1;
          a_d     = '0;
          b_d     = '0;
          op_d    = OP_NONE;
          ent_d   = 1'b0;
          res_d   = 1'b0;
          err_d   = 1'b0;
        end
      endcase
    end

    if (do_echo) begin
      state_d = S_WRITE;
      idx_d   = '0;
      echo_d  = 1'b1;
      buf_d   = to_disp(ent_d ? b_d : a_d);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NONE;
      prev_q  <= 8'h00;
      a_q     <= '0;
      b_q     <= '0;
      ent_q   <= 1'b0;
      res_q   <= 1'b0;
      err_q   <= 1'b0;
      echo_q  <= 1'b0;
      idx_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      prev_q  <= prev_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ent_q   <= ent_d;
      res_q   <= res_d;
      err_q   <= err_d;
      echo_q  <= echo_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_calculadora.sv
// Bench for calculadora: expected display writes are queued
// as commands are driven and popped as strobes appear.
module tb_calculadora;

  logic       clk;
  logic       rst;
  logic [7:0] CMD;
  logic       busy;
  logic       error;
  logic [3:0] display_val;
  logic [2:0] display_idx;
  logic       display_wr;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  logic [6:0] sb[$];

  calculadora dut (
    .clk         (clk),
    .rst         (rst),
    .CMD         (CMD),
    .busy        (busy),
    .error       (error),
    .display_val (display_val),
    .display_idx (display_idx),
    .display_wr  (display_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_num(input int unsigned v);
    int unsigned t;
    logic [3:0]  d;
    t = v;
    for (int i = 0; i < 8; i++) begin
      if (i > 0 && t == 0) d = 4'hF;
      else d = 4'(t % 10);
      sb.push_back({3'(i), d});
      t = t / 10;
    end
  endtask

  task automatic push_err();
    for (int i = 0; i < 8; i++) sb.push_back({3'(i), 4'hE});
  endtask

  task automatic press(input logic [7:0] c, input int hold);
    CMD = c;
    repeat (hold) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic [7:0] c);
    press(c, 1);
    press(8'hFF, 11);
  endtask

  task automatic equals();
    int n;
    press(8'h0D, 1);
    chk("busy_rise", 32'(busy), 1);
    n = 0;
    while (busy && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("busy_len", n, 9);
    press(8'hFF, 2);
  endtask

  always @(negedge clk) begin
    if (mon_en && display_wr) begin
      chk("sb_nonempty", 32'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        logic [6:0] e;
        e = sb.pop_front();
        chk("wr_idx", 32'(display_idx), 32'(e[6:4]));
        chk("wr_val", 32'(display_val), 32'(e[3:0]));
      end
    end
  end

  initial begin
    rst = 1'b0;
    CMD = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_err", 32'(error), 0);
    chk("rst_wr", 32'(display_wr), 0);
    chk("rst_val", 32'(display_val), 0);
    chk("rst_idx", 32'(display_idx), 0);
    rst = 1'b1;
    mon_en = 1'b1;
    press(8'h00, 2);

    // 5 + 3
    push_num(5);
    press(8'h05, 2);
    press(8'hFF, 11);
    key(8'h0A);
    push_num(3);
    key(8'h03);
    push_num(8);
    equals();
    chk("t1_err", 32'(error), 0);

    // 9 * 9
    push_num(9);
    key(8'h09);
    key(8'h0C);
    push_num(9);
    key(8'h09);
    push_num(81);
    equals();

    // 3 - 5 -> error, digit ignored, clear
    push_num(3);
    key(8'h03);
    key(8'h0B);
    push_num(5);
    key(8'h05);
    push_err();
    equals();
    chk("t3_err", 32'(error), 1);
    key(8'h07);
    chk("t3_err_hold", 32'(error), 1);
    push_num(0);
    key(8'h0F);
    chk("t3_clr", 32'(error), 0);

    // 99999999, 9th digit, * 2 -> overflow
    begin
      int unsigned v;
      v = 0;
      for (int i = 0; i < 8; i++) begin
        v = v * 10 + 9;
        push_num(v);
        key(8'h09);
      end
    end
    push_num(99999999);
    key(8'h09);
    key(8'h0C);
    push_num(2);
    key(8'h02);
    push_err();
    equals();
    chk("t4_err", 32'(error), 1);
    push_num(0);
    key(8'h0F);

    // backspace and chaining
    push_num(1);
    key(8'h01);
    push_num(12);
    key(8'h02);
    push_num(123);
    key(8'h03);
    push_num(12);
    key(8'h0E);
    key(8'h0A);
    push_num(4);
    key(8'h04);
    push_num(16);
    equals();
    key(8'h0A);
    push_num(1);
    key(8'h01);
    push_num(17);
    equals();

    // held key accepted once
    push_num(5);
    press(8'h05, 10);
    press(8'hFF, 10);

    // commands during busy are dropped
    key(8'h0A);
    push_num(3);
    key(8'h03);
    push_num(8);
    press(8'h0D, 1);
    chk("t6_busy", 32'(busy), 1);
    press(8'h07, 1);
    press(8'hFF, 1);
    press(8'h06, 1);
    press(8'hFF, 12);
    chk("t6_idle", 32'(busy), 0);
    key(8'h0A);
    push_num(1);
    key(8'h01);
    push_num(9);
    equals();

    // reset in the middle of a result write
    mon_en = 1'b0;
    press(8'h0D, 1);
    press(8'hFF, 3);
    chk("mid_busy", 32'(busy), 1);
    chk("mid_wr", 32'(display_wr), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_wr", 32'(display_wr), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_idx", 32'(display_idx), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    mon_en = 1'b1;
    press(8'hFF, 2);
    push_num(7);
    key(8'h07);
    chk("post_err", 32'(error), 0);

    press(8'hFF, 5);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
